// File: rtl/mem_stage_pkg.sv
// Shared definitions for the pipeline memory stage: access-size encodings,
// byte-enable patterns, FSM states and the latched request / writeback records.
package mem_stage_pkg;

    // funct3 load/store size encodings; bit 2 selects zero-extension on loads.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic        regwrite;
        logic        memtoreg;
    } mem_req_t;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic [4:0]  rd;
        logic [31:0] result;
        logic        misalign;
        logic        buserr;
    } wb_out_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane select and sign/zero extension of the returned bus word.
module load_extend
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] result_o
);

    logic [15:0] lane;

    // NOTE: every variable written in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        lane = 16'(rdata_i >> {addr_lo_i, 3'b000});
        case (funct3_i)
            F3_B:    result_o = {{24{lane[7]}}, lane[7:0]};
            F3_H:    result_o = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   result_o = {24'h0, lane[7:0]};
            F3_HU:   result_o = {16'h0, lane[15:0]};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: issues one data-memory access at a time, stalls upstream
// until ack or timeout, and registers the result toward writeback.
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DMEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        Ctl_RegWrite_in,
    input  logic        Ctl_MemRead_in,
    input  logic        Ctl_MemWrite_in,
    input  logic        Ctl_MemtoReg_in,
    input  logic [2:0]  funct3_in,
    input  logic [4:0]  Rd_in,
    input  logic [31:0] ALUresult_in,
    input  logic [31:0] Rs2data_in,
    input  logic        Flush_in,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [31:0] dmem_addr_out,
    output logic [31:0] dmem_wdata_out,
    output logic [3:0]  dmem_be_out,
    input  logic        dmem_ack_in,
    input  logic [31:0] dmem_rdata_in,
    output logic        Stall_out,
    output logic        Ctl_RegWrite_out,
    output logic [4:0]  Rd_out,
    output logic [31:0] MEMresult_out,
    output logic        valid_out,
    output logic        Misalign_out,
    output logic        BusErr_out
);

    localparam int unsigned CNT_W = $clog2(DMEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DMEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             killed_q, killed_d;
    mem_req_t         req_q, req_d;
    wb_out_t          wb_q, wb_d;

    logic             is_mem_op;
    logic             stall_c;
    logic             killed_now;
    logic [3:0]       st_be;
    logic [31:0]      st_wdata;
    logic [31:0]      load_result;

    assign is_mem_op  = Ctl_MemRead_in | Ctl_MemWrite_in;
    assign killed_now = killed_q | Flush_in;

    always_comb begin
        case (funct3_in[1:0])
            SZ_BYTE: begin
                st_be    = BE_BYTE << ALUresult_in[1:0];
                st_wdata = {4{Rs2data_in[7:0]}};
            end
            SZ_HALF: begin
                st_be    = BE_HALF << ALUresult_in[1:0];
                st_wdata = {2{Rs2data_in[15:0]}};
            end
            default: begin
                st_be    = BE_WORD;
                st_wdata = Rs2data_in;
            end
        endcase
    end

    load_extend u_load_extend (
        .funct3_i  (req_q.funct3),
        .addr_lo_i (req_q.addr[1:0]),
        .rdata_i   (dmem_rdata_in),
        .result_o  (load_result)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        killed_d = killed_q;
        req_d    = req_q;
        wb_d     = '0;
        stall_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (valid_in && !Flush_in) begin
                    if (!is_mem_op) begin
                        wb_d.valid    = 1'b1;
                        wb_d.regwrite = Ctl_RegWrite_in && (Rd_in != 5'd0);
                        wb_d.rd       = Rd_in;
                        wb_d.result   = ALUresult_in;
                    end else if (is_misaligned(funct3_in[1:0], ALUresult_in[1:0])) begin
                        wb_d.misalign = 1'b1;
                    end else begin
                        state_d        = S_WAIT;
                        cnt_d          = '0;
                        killed_d       = 1'b0;
                        stall_c        = 1'b1;
                        req_d.addr     = ALUresult_in;
                        req_d.wdata    = st_wdata;
                        req_d.be       = st_be;
                        req_d.we       = Ctl_MemWrite_in;
                        req_d.funct3   = funct3_in;
                        req_d.rd       = Rd_in;
                        req_d.regwrite = Ctl_RegWrite_in;
                        req_d.memtoreg = Ctl_MemtoReg_in;
                    end
                end
            end

            S_WAIT: begin
                cnt_d    = cnt_q + CNT_W'(1);
                killed_d = killed_now;
                // Ack wins over a timeout falling in the same cycle.
                if (dmem_ack_in) begin
                    state_d = S_IDLE;
                    if (!killed_now) begin
                        wb_d.valid    = 1'b1;
                        wb_d.regwrite = req_q.regwrite && (req_q.rd != 5'd0);
                        wb_d.rd       = req_q.rd;
                        wb_d.result   = req_q.memtoreg ? load_result : req_q.addr;
                    end
                end else begin
                    stall_c = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d     = S_IDLE;
                        wb_d.buserr = 1'b1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            killed_q <= 1'b0;
            req_q    <= '0;
            wb_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            killed_q <= killed_d;
            req_q    <= req_d;
            wb_q     <= wb_d;
        end
    end

    // Stall is combinational, so it is gated to keep it low while reset is held.
    assign Stall_out        = stall_c & rst_n;

    assign dmem_req_out     = (state_q == S_WAIT);
    assign dmem_we_out      = req_q.we;
    assign dmem_addr_out    = req_q.addr;
    assign dmem_wdata_out   = req_q.wdata;
    assign dmem_be_out      = req_q.be;

    assign valid_out        = wb_q.valid;
    assign Ctl_RegWrite_out = wb_q.regwrite;
    assign Rd_out           = wb_q.rd;
    assign MEMresult_out    = wb_q.result;
    assign Misalign_out     = wb_q.misalign;
    assign BusErr_out       = wb_q.buserr;

endmodule
